// File: rtl/plot_sink.sv
// plot_sink: pixel-plot receiver with an internal WIDTHxHEIGHT framebuffer, clear sweep, readback and statistics
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   vga_x, vga_y, vga_colour, vga_plot  plot input, one pixel per cycle, no backpressure
//   clear, clear_colour, busy           fill request, fill colour, high while the fill sweep runs
//   rd_en, rd_x, rd_y                   readback request
//   rd_valid, rd_colour                 readback result, one cycle after the request
//   plot_count, drop_count              accepted plots since last clear, dropped plots since reset
module plot_sink #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic        clear,
    input  logic [2:0]  clear_colour,
    output logic        busy,
    input  logic        rd_en,
    input  logic [7:0]  rd_x,
    input  logic [6:0]  rd_y,
    output logic        rd_valid,
    output logic [2:0]  rd_colour,
    output logic [15:0] plot_count,
    output logic [15:0] drop_count
);
    localparam int DEPTH = WIDTH * HEIGHT;

    typedef enum logic {ACCEPT, CLEAR} state_t;

    state_t      state;
    logic [14:0] ptr, plot_addr, rd_addr, wr_addr;
    logic [2:0]  fill, wr_data, rd_q;
    logic [2:0]  mem [DEPTH];
    logic        plot_in, rd_in, take_clear, take_plot, drop, we, rd_ok;

    assign plot_in    = 32'(vga_x) < WIDTH && 32'(vga_y) < HEIGHT;
    assign rd_in      = 32'(rd_x) < WIDTH && 32'(rd_y) < HEIGHT;
    assign plot_addr  = 15'(32'(vga_y) * WIDTH + 32'(vga_x));
    // Out-of-range reads are parked on address 0 and masked to 0 on the output
    assign rd_addr    = rd_in ? 15'(32'(rd_y) * WIDTH + 32'(rd_x)) : '0;
    assign busy       = state == CLEAR;
    assign take_clear = state == ACCEPT && clear;
    assign take_plot  = state == ACCEPT && !clear && vga_plot && plot_in;
    assign drop       = vga_plot && !take_plot;
    // No memory writes while reset is held; the sweep restarts after release
    assign we         = rst_n && (busy || take_plot);
    assign wr_addr    = busy ? ptr : plot_addr;
    assign wr_data    = busy ? fill : vga_colour;
    assign rd_colour  = rd_ok ? rd_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            ptr        <= '0;
            fill       <= '0;
            plot_count <= '0;
            drop_count <= '0;
            rd_valid   <= 1'b0;
            rd_ok      <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_ok    <= rd_en && rd_in;
            if (drop && drop_count != '1)
                drop_count <= drop_count + 1'b1;
            if (take_clear)
                plot_count <= '0;
            else if (take_plot && plot_count != '1)
                plot_count <= plot_count + 1'b1;
            if (busy) begin
                ptr <= ptr + 1'b1;
                if (ptr == 15'(DEPTH - 1))
                    state <= ACCEPT;
            end else if (clear) begin
                fill  <= clear_colour;
                ptr   <= '0;
                state <= CLEAR;
            end
        end
    end

    // Read and write share one block so a same-address read returns the old data
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
        rd_q <= mem[rd_addr];
    end
endmodule

// File: tb/tb_plot_sink.sv
// tb_plot_sink: directed checks of plot_sink (reset sweep, fill, drops, clear, read-before-write, mid-sweep reset)
module tb_plot_sink;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  vga_x = '0;
    logic [6:0]  vga_y = '0;
    logic [2:0]  vga_colour = '0;
    logic        vga_plot = 1'b0;
    logic        clear = 1'b0;
    logic [2:0]  clear_colour = '0;
    logic        busy;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_x = '0;
    logic [6:0]  rd_y = '0;
    logic        rd_valid;
    logic [2:0]  rd_colour;
    logic [15:0] plot_count;
    logic [15:0] drop_count;

    int vectors = 0;
    int miscompares = 0;

    plot_sink dut (
        .clk(clk), .rst_n(rst_n), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .clear(clear), .clear_colour(clear_colour), .busy(busy),
        .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid), .rd_colour(rd_colour),
        .plot_count(plot_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int x, input int y);
        rd_en = 1'b1;
        rd_x = 8'(x);
        rd_y = 7'(y);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 25000) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        repeat (3) tick();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b want 1", busy); end
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        vectors++; if (rd_colour !== 3'd0) begin miscompares++; $display("FAIL reset_rd_colour: got %0d want 0", rd_colour); end
        vectors++; if (plot_count !== 16'd0) begin miscompares++; $display("FAIL reset_plot_count: got %0d want 0", plot_count); end
        vectors++; if (drop_count !== 16'd0) begin miscompares++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
        rst_n = 1'b1;
        wait_busy(n);
        vectors++; if (n != 19200) begin miscompares++; $display("FAIL reset_sweep_len: got %0d want 19200", n); end
        rd(0, 0);
        vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL reset_rd_valid_00: got %b want 1", rd_valid); end
        vectors++; if (rd_colour !== 3'd0) begin miscompares++; $display("FAIL reset_px_00: got %0d want 0", rd_colour); end
        rd(159, 119);
        vectors++; if (rd_colour !== 3'd0) begin miscompares++; $display("FAIL reset_px_last: got %0d want 0", rd_colour); end
        tick();
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL idle_rd_valid: got %b want 0", rd_valid); end
        vectors++; if (plot_count !== 16'd0 || drop_count !== 16'd0) begin miscompares++; $display("FAIL reset_counts: got %0d/%0d want 0/0", plot_count, drop_count); end
    endtask

    task automatic test_fill();
        vga_plot = 1'b1;
        vga_colour = 3'b101;
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++) begin
                vga_x = 8'(x);
                vga_y = 7'(y);
                tick();
            end
        vga_plot = 1'b0;
        vectors++; if (plot_count !== 16'd19200) begin miscompares++; $display("FAIL fill_plot_count: got %0d want 19200", plot_count); end
        vectors++; if (drop_count !== 16'd0) begin miscompares++; $display("FAIL fill_drop_count: got %0d want 0", drop_count); end
        for (int i = 0; i < 6; i++) begin
            int x, y;
            x = int'($urandom_range(159));
            y = int'($urandom_range(119));
            rd(x, y);
            vectors++; if (rd_colour !== 3'b101) begin miscompares++; $display("FAIL fill_px(%0d,%0d): got %0d want 5", x, y, rd_colour); end
        end
    endtask

    task automatic test_drops();
        vga_plot = 1'b1;
        vga_colour = 3'b011;
        vga_x = 8'd160; vga_y = 7'd0;   tick();
        vga_x = 8'd0;   vga_y = 7'd120; tick();
        vga_x = 8'd255; vga_y = 7'd127; tick();
        vga_plot = 1'b0;
        vectors++; if (drop_count !== 16'd3) begin miscompares++; $display("FAIL drops_drop_count: got %0d want 3", drop_count); end
        vectors++; if (plot_count !== 16'd19200) begin miscompares++; $display("FAIL drops_plot_count: got %0d want 19200", plot_count); end
        rd(0, 0);
        vectors++; if (rd_colour !== 3'b101) begin miscompares++; $display("FAIL drops_px_00: got %0d want 5", rd_colour); end
        rd(200, 10);
        vectors++; if (rd_valid !== 1'b1 || rd_colour !== 3'd0) begin miscompares++; $display("FAIL oob_read: got %b/%0d want 1/0", rd_valid, rd_colour); end
    endtask

    task automatic test_clear();
        int n;
        clear = 1'b1;
        clear_colour = 3'b010;
        vga_plot = 1'b1;
        vga_x = 8'd5; vga_y = 7'd5; vga_colour = 3'b111;
        tick();
        clear = 1'b0;
        clear_colour = 3'b110;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL clear_busy: got %b want 1", busy); end
        vectors++; if (plot_count !== 16'd0) begin miscompares++; $display("FAIL clear_plot_count: got %0d want 0", plot_count); end
        vectors++; if (drop_count !== 16'd4) begin miscompares++; $display("FAIL clear_drop_same_cycle: got %0d want 4", drop_count); end
        clear = 1'b1;
        vga_x = 8'd1; vga_y = 7'd1;
        repeat (5) tick();
        clear = 1'b0;
        vga_plot = 1'b0;
        vectors++; if (drop_count !== 16'd9) begin miscompares++; $display("FAIL clear_drop_busy: got %0d want 9", drop_count); end
        wait_busy(n);
        vectors++; if (n != 19195) begin miscompares++; $display("FAIL clear_sweep_len: got %0d want 19195", n); end
        rd(5, 5);
        vectors++; if (rd_colour !== 3'b010) begin miscompares++; $display("FAIL clear_px_55: got %0d want 2", rd_colour); end
        rd(1, 1);
        vectors++; if (rd_colour !== 3'b010) begin miscompares++; $display("FAIL clear_px_11: got %0d want 2", rd_colour); end
        vectors++; if (plot_count !== 16'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL clear_after: got %0d/%b want 0/0", plot_count, busy); end
    endtask

    task automatic test_rbw();
        vga_plot = 1'b1;
        vga_x = 8'd10; vga_y = 7'd20; vga_colour = 3'b111;
        rd_en = 1'b1;
        rd_x = 8'd10; rd_y = 7'd20;
        tick();
        vga_plot = 1'b0;
        vectors++; if (rd_valid !== 1'b1 || rd_colour !== 3'b010) begin miscompares++; $display("FAIL rbw_old: got %b/%0d want 1/2", rd_valid, rd_colour); end
        tick();
        rd_en = 1'b0;
        vectors++; if (rd_colour !== 3'b111) begin miscompares++; $display("FAIL rbw_new: got %0d want 7", rd_colour); end
        vectors++; if (plot_count !== 16'd1) begin miscompares++; $display("FAIL rbw_plot_count: got %0d want 1", plot_count); end
        tick();
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL rbw_valid_drop: got %b want 0", rd_valid); end
    endtask

    task automatic test_reset_mid();
        int n;
        clear = 1'b1;
        clear_colour = 3'b011;
        tick();
        clear = 1'b0;
        vga_plot = 1'b1;
        vga_x = 8'd0; vga_y = 7'd0;
        repeat (2) tick();
        vga_plot = 1'b0;
        rd_en = 1'b1;
        rd_x = 8'd5; rd_y = 7'd5;
        repeat (100) tick();
        vectors++; if (busy !== 1'b1 || drop_count !== 16'd11) begin miscompares++; $display("FAIL mid_pre: got %b/%0d want 1/11", busy, drop_count); end
        vectors++; if (rd_valid !== 1'b1 || rd_colour !== 3'b010) begin miscompares++; $display("FAIL mid_pre_read: got %b/%0d want 1/2", rd_valid, rd_colour); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b want 1", busy); end
        vectors++; if (rd_valid !== 1'b0 || rd_colour !== 3'd0) begin miscompares++; $display("FAIL mid_rd: got %b/%0d want 0/0", rd_valid, rd_colour); end
        vectors++; if (drop_count !== 16'd0 || plot_count !== 16'd0) begin miscompares++; $display("FAIL mid_counts: got %0d/%0d want 0/0", drop_count, plot_count); end
        rd_en = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        wait_busy(n);
        vectors++; if (n != 19200) begin miscompares++; $display("FAIL mid_sweep_len: got %0d want 19200", n); end
        rd(5, 5);
        vectors++; if (rd_colour !== 3'd0) begin miscompares++; $display("FAIL mid_px_55: got %0d want 0", rd_colour); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drops();
        test_clear();
        test_rbw();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
